// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI frame/command controller.
//   state_t      : controller FSM states
//   CMD_RW_BIT   : command byte read/write flag (1 = read)
//   CMD_ADDR_MSB : top bit of the command address field
//   IDLE_MISO    : byte returned on MISO when no read data is pending
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      S_CMD,
      S_RD_LAT,
      S_RD_CAP,
      S_DATA,
      S_HOLD
   } state_t;

   localparam int unsigned CMD_RW_BIT   = 7;
   localparam int unsigned CMD_ADDR_MSB = 6;
   localparam logic [7:0]  IDLE_MISO    = 8'h00;

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Bus between the SPI byte bridge, the controller and the register bank.
//   cs_n, byte_sync, data_in : from the byte bridge (raw chip select, byte strobe, byte)
//   data_out                 : byte for the next MISO slot
//   reg_addr/reg_wr/reg_wdata/reg_rd : register bank access strobes
//   reg_rdata                : register read data, valid the cycle after reg_rd
//   addr_err, busy           : status
// Modports: slave = controller side, master = bridge/register-bank side.
interface spi_reg_ctrl_if #(
   parameter int unsigned ADDR_W = 6
);

   logic              cs_n;
   logic              byte_sync;
   logic [7:0]        data_in;
   logic [7:0]        data_out;
   logic [ADDR_W-1:0] reg_addr;
   logic              reg_wr;
   logic [7:0]        reg_wdata;
   logic              reg_rd;
   logic [7:0]        reg_rdata;
   logic              addr_err;
   logic              busy;

   modport slave (
      input  cs_n, byte_sync, data_in, reg_rdata,
      output data_out, reg_addr, reg_wr, reg_wdata, reg_rd, addr_err, busy
   );

   modport master (
      output cs_n, byte_sync, data_in, reg_rdata,
      input  data_out, reg_addr, reg_wr, reg_wdata, reg_rd, addr_err, busy
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (RST_VAL while in reset)
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame/command controller. Decodes command byte + data bytes from the
// byte bridge, issues single-cycle read/write strobes to the register bank
// and loads read data into data_out for the next MISO slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_reg_ctrl_if.slave (see interface header)
// Build option: define SPI_AUTO_INC_EN for burst access with address
// auto-increment (wrapping NUM_REGS-1 -> 0); otherwise one data byte per frame.
module spi_reg_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned NUM_REGS = 20
) (
   input  logic           clk,
   input  logic           rst_n,
   spi_reg_ctrl_if.slave  bus
);

   localparam logic [7:0]        NREG8     = 8'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   logic cs_s;

   sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.cs_n),
      .q_o   (cs_s)
   );

   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [ADDR_W-1:0] reg_addr_q,  reg_addr_d;
   logic [7:0]        reg_wdata_q, reg_wdata_d;
   logic [7:0]        data_out_q,  data_out_d;
   logic              rw_q,        rw_d;
   logic              reg_wr_q,    reg_wr_d;
   logic              reg_rd_q,    reg_rd_d;
   logic              addr_err_q,  addr_err_d;

   logic cmd_valid;
   assign cmd_valid = {1'b0, bus.data_in[CMD_ADDR_MSB:0]} < NREG8;

`ifdef SPI_AUTO_INC_EN
   logic [ADDR_W-1:0] next_addr;
   assign next_addr = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      data_out_d  = data_out_q;
      rw_d        = rw_q;
      reg_wr_d    = 1'b0;
      reg_rd_d    = 1'b0;
      addr_err_d  = 1'b0;

      // Deselect wins over any byte_sync in the same cycle.
      if (cs_s) begin
         state_d    = S_CMD;
         data_out_d = IDLE_MISO;
      end else begin
         unique case (state_q)
            S_CMD: if (bus.byte_sync) begin
               rw_d = bus.data_in[CMD_RW_BIT];
               if (!cmd_valid) begin
                  addr_err_d = 1'b1;
                  data_out_d = IDLE_MISO;
                  state_d    = S_HOLD;
               end else begin
                  addr_d     = bus.data_in[ADDR_W-1:0];
                  reg_addr_d = bus.data_in[ADDR_W-1:0];
                  if (bus.data_in[CMD_RW_BIT]) begin
                     reg_rd_d = 1'b1;
                     state_d  = S_RD_LAT;
                  end else begin
                     state_d  = S_DATA;
                  end
               end
            end
            S_RD_LAT: state_d = S_RD_CAP;
            S_RD_CAP: begin
               data_out_d = bus.reg_rdata;
               state_d    = S_DATA;
            end
            S_DATA: if (bus.byte_sync) begin
               if (!rw_q) begin
                  reg_wr_d    = 1'b1;
                  reg_wdata_d = bus.data_in;
                  reg_addr_d  = addr_q;
               end
`ifdef SPI_AUTO_INC_EN
               // addr_q runs one ahead of reg_addr so the write strobe
               // carries the address it was issued for.
               addr_d = next_addr;
               if (rw_q) begin
                  reg_addr_d = next_addr;
                  reg_rd_d   = 1'b1;
                  state_d    = S_RD_LAT;
               end
`else
               data_out_d = IDLE_MISO;
               state_d    = S_HOLD;
`endif
            end
            S_HOLD:  data_out_d = IDLE_MISO;
            default: state_d    = S_CMD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_CMD;
         addr_q      <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         data_out_q  <= '0;
         rw_q        <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_rd_q    <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         data_out_q  <= data_out_d;
         rw_q        <= rw_d;
         reg_wr_q    <= reg_wr_d;
         reg_rd_q    <= reg_rd_d;
         addr_err_q  <= addr_err_d;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.reg_addr  = reg_addr_q;
   assign bus.reg_wr    = reg_wr_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.reg_rd    = reg_rd_q;
   assign bus.addr_err  = addr_err_q;
   assign bus.busy      = ~cs_s;

endmodule
